// File: rtl/camera_pkg.sv
// Shared camera definitions: direction codes, controller FSM states and the
// vector type used by the camera datapath.
package camera_pkg;

    typedef logic [2:0] key_code_t;

    localparam key_code_t UPOS = 3'b000;
    localparam key_code_t UNEG = 3'b001;
    localparam key_code_t VPOS = 3'b010;
    localparam key_code_t VNEG = 3'b011;
    localparam key_code_t WPOS = 3'b100;
    localparam key_code_t WNEG = 3'b101;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;
    localparam logic [1:0] ISSUE    = 2'd3;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
    } vector_t;

    // One-hot three-phase ring: v0 -> v1 -> v2 -> v0.
    function automatic logic [2:0] rotate_phase(input logic [2:0] p);
        return {p[1:0], p[2]};
    endfunction

endpackage

// File: rtl/camera_input_ctrl_key_debounce.sv
// Key front end: 2-FF synchronizer, lowest-index priority encoder and the
// stability counter that qualifies a candidate code.
module key_debounce
    import camera_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic [5:0] keys,
    input  logic      arm,
    input  logic      counting,
    output key_code_t code,
    output logic      valid,
    output logic      match,
    output logic      stable
);

    logic [5:0]  sync1_reg;
    logic [5:0]  sync2_reg;
    key_code_t   cand_reg;
    logic [31:0] dcnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= keys;
            sync2_reg <= sync1_reg;
        end
    end

    // Descending scan so the lowest set index overrides higher ones.
    always_comb begin
        code  = UPOS;
        valid = |sync2_reg;
        for (int i = 5; i >= 0; i--) begin
            if (sync2_reg[i]) code = 3'(i);
        end
    end

    assign match  = valid && (code == cand_reg);
    assign stable = counting && match && (dcnt_reg == 32'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_reg <= UPOS;
            dcnt_reg <= '0;
        end else if (arm) begin
            cand_reg <= code;
            dcnt_reg <= '0;
        end else if (counting && match && !stable) begin
            dcnt_reg <= dcnt_reg + 32'd1;
        end
    end

endmodule

// File: rtl/camera_input_ctrl.sv
// Camera input controller: debounced key direction, held-key movement count
// and a three-cycle camera load request aligned to the phase ring.
module camera_input_ctrl
    import camera_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_CYCLES     = 50000,
    parameter int CNT_MAX         = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  keys,
    input  logic        frame_done,
    output logic [2:0]  key,
    output logic [31:0] cnt,
    output logic        ld_curr_camera,
    output logic        v0,
    output logic        v1,
    output logic        v2
);

    key_code_t   code;
    logic        valid;
    logic        match;
    logic        stable;
    logic        arm;
    logic        counting;
    logic        key_held;

    logic [1:0]  state_reg;
    key_code_t   key_reg;
    logic [31:0] cnt_reg;
    logic [31:0] tick_reg;
    logic        ld_reg;
    logic [2:0]  phase_reg;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk     (clk),
        .rst     (rst),
        .keys    (keys),
        .arm     (arm),
        .counting(counting),
        .code    (code),
        .valid   (valid),
        .match   (match),
        .stable  (stable)
    );

    assign arm      = (state_reg == IDLE) && valid;
    assign counting = (state_reg == DEBOUNCE);
    assign key_held = valid && (code == key_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_reg <= 3'b001;
        else     phase_reg <= rotate_phase(phase_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            key_reg   <= UPOS;
            cnt_reg   <= '0;
            tick_reg  <= '0;
            ld_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid) state_reg <= DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (!match) begin
                        state_reg <= IDLE;
                    end else if (stable) begin
                        state_reg <= HOLD;
                        key_reg   <= code;
                        cnt_reg   <= '0;
                        tick_reg  <= '0;
                    end
                end
                HOLD: begin
                    // Release and frame boundary together still give one ISSUE.
                    if ((frame_done || !key_held) && (cnt_reg != 32'd0)) begin
                        state_reg <= ISSUE;
                    end else if (!key_held) begin
                        state_reg <= IDLE;
                    end else if (tick_reg == 32'(TICK_CYCLES - 1)) begin
                        tick_reg <= '0;
                        if (cnt_reg != 32'(CNT_MAX)) cnt_reg <= cnt_reg + 32'd1;
                    end else begin
                        tick_reg <= tick_reg + 32'd1;
                    end
                end
                ISSUE: begin
                    // Raise on the v2 edge so the pulse covers v0, v1, v2.
                    if (!ld_reg) begin
                        if (phase_reg[2]) ld_reg <= 1'b1;
                    end else if (phase_reg[2]) begin
                        ld_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        tick_reg  <= '0;
                        state_reg <= key_held ? HOLD : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign key            = key_reg;
    assign cnt            = cnt_reg;
    assign ld_curr_camera = ld_reg;
    assign v0             = phase_reg[0];
    assign v1             = phase_reg[1];
    assign v2             = phase_reg[2];

endmodule

// File: doc/camera_input_ctrl.md
CAMERA_INPUT_CTRL -- requirements
Module: camera_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles needed to accept a key.
REQ-002 SHALL have parameter TICK_CYCLES, default 50000: held-key cycles per movement count.
REQ-003 SHALL have parameter CNT_MAX, default 1023: saturation value of cnt.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port keys, input, 6: raw asynchronous buttons; bit0 U+, bit1 U-, bit2 V+, bit3 V-, bit4 W+, bit5 W-.
REQ-007 SHALL have port frame_done, input, 1: one-cycle pulse at frame boundary; camera update permitted.
REQ-008 SHALL have port key, output, 3: direction code to camera datapath (UPOS 000, UNEG 001, VPOS 010, VNEG 011, WPOS 100, WNEG 101).
REQ-009 SHALL have port cnt, output, 32: unsigned movement count for key.
REQ-010 SHALL have port ld_curr_camera, output, 1: camera update request.
REQ-011 SHALL have ports v0, v1, v2, output, 1 each: one-hot three-phase strobe.

Function
REQ-012 SHALL pass keys through a 2-FF synchronizer before any use.
REQ-013 SHALL priority-encode synced keys, lowest index wins; all-zero means no key.
REQ-014 SHALL rotate phase v0->v1->v2->v0 every cycle, unconditionally, exactly one asserted.
REQ-015 SHALL implement FSM states IDLE, DEBOUNCE, HOLD, ISSUE.
REQ-016 IDLE: on any key, latch its code as candidate, clear debounce counter, go DEBOUNCE.
REQ-017 DEBOUNCE: candidate unchanged for DEBOUNCE_CYCLES consecutive cycles -> HOLD, key output <= candidate, cnt <= 0, tick counter <= 0; code change or release -> IDLE.
REQ-018 DEBOUNCE and IDLE SHALL ignore frame_done.
REQ-019 HOLD: tick counter increments each cycle; on reaching TICK_CYCLES-1 it wraps to 0 and cnt increments, saturating at CNT_MAX.
REQ-020 HOLD: frame_done with cnt != 0 -> ISSUE; frame_done with cnt == 0 ignored.
REQ-021 HOLD: release or code change with cnt != 0 -> ISSUE immediately; with cnt == 0 -> IDLE.
REQ-022 HOLD: frame_done coincident with release -> single ISSUE.
REQ-023 ISSUE: wait until v0 = 1, then assert ld_curr_camera for exactly 3 cycles (v0, v1, v2).
REQ-024 key and cnt SHALL be frozen for the whole of ISSUE; tick counting suspended; key changes do not abort ISSUE.
REQ-025 After the third ld cycle: cnt <= 0, tick <= 0; same code still held -> HOLD, else IDLE.
REQ-026 key output SHALL retain last accepted code in IDLE/DEBOUNCE.

Reset
REQ-027 On rst: state IDLE, key = 000, cnt = 0, ld_curr_camera = 0, v0 = 1, v1 = 0, v2 = 0, all counters and synchronizer flops 0.
REQ-028 rst during ISSUE SHALL deassert ld_curr_camera immediately, with no completion of the pulse after release.

Structure
REQ-029 Key-code constants (UPOS..WNEG) and the FSM state enum SHALL live in the shared camera package alongside vector_t.
REQ-030 Synchronizer, priority encoder and debounce counter SHALL form sub-module key_debounce; FSM, tick/cnt counters and phase ring stay in top.

Verification (bench params DEBOUNCE_CYCLES=4, TICK_CYCLES=2, CNT_MAX=7)
REQ-031 Reset pulse -> v0=1, ld=0, key=000, cnt=0; next cycles v1, v2, v0.
REQ-032 keys[3] high for 2 cycles then low -> ld never asserts, key stays 000, FSM returns IDLE.
REQ-033 keys[2] held, frame_done 10 cycles after HOLD entry -> key=010, cnt=5, ld high 3 cycles starting on v0, cnt=0 afterwards, FSM back to HOLD.
REQ-034 keys[5] held 40 HOLD cycles, then frame_done -> key=101, cnt=7 (saturated).
REQ-035 keys[0] and keys[4] together, released after 6 HOLD cycles, no frame_done -> key=000, immediate ISSUE with cnt=3, then IDLE.
REQ-036 rst asserted during second ld cycle -> ld=0 same cycle, state IDLE, v0=1, cnt=0.
